noc_injector: RTL and testbench

- Network-interface transmit stage. Sits directly upstream of a router's local input port.
- Converts a packet command plus a payload word stream into a head/body/tail flit sequence on one of the local port's virtual channels.
- Obeys per-VC on/off and VC-allocatable flow control returned by the router.
- Output pins connect one-to-one to the router's local-port data_in / is_valid_in, and the router's local is_on_off_out / is_allocatable_out.

---
 rtl/noc_injector.sv | 173 +++++++++++++++++
 tb/tb_noc_injector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_injector.sv
// Network-interface transmit stage: turns a packet command plus a payload word
// stream into head/body/tail flits on one virtual channel of a router local port.
package noc_injector_pkg;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DATA_W      = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t              flit_label;
    logic [VC_SIZE-1:0]       vc_id;
    logic [FLIT_DATA_W-1:0]   data;
  } flit_t;
endpackage

module noc_injector #(
  parameter int VC_NUM = noc_injector_pkg::VC_NUM,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cmd_valid_i,
  output logic                                          cmd_ready_o,
  input  logic [noc_injector_pkg::DEST_ADDR_SIZE_X-1:0] cmd_x_dest_i,
  input  logic [noc_injector_pkg::DEST_ADDR_SIZE_Y-1:0] cmd_y_dest_i,
  input  logic [LEN_W-1:0]                              cmd_len_i,
  input  logic                                          pl_valid_i,
  output logic                                          pl_ready_o,
  input  logic [noc_injector_pkg::FLIT_DATA_W-1:0]      pl_data_i,
  output noc_injector_pkg::flit_t                       data_o,
  output logic                                          valid_o,
  input  logic [VC_NUM-1:0]                             on_off_i,
  input  logic [VC_NUM-1:0]                             allocatable_i,
  output logic                                          busy_o,
  output logic [CNT_W-1:0]                              sent_cnt_o
);

  localparam int X_W   = noc_injector_pkg::DEST_ADDR_SIZE_X;
  localparam int Y_W   = noc_injector_pkg::DEST_ADDR_SIZE_Y;
  localparam int VC_W  = noc_injector_pkg::VC_SIZE;
  localparam int PAD_W = noc_injector_pkg::FLIT_DATA_W - X_W - Y_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_HEAD,
    ST_BODY
  } state_t;

  state_t                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [VC_W-1:0]         vc_q, vc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  noc_injector_pkg::flit_t data_q, data_d;
  logic [VC_NUM-1:0]       cand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      vc_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      vc_q    <= vc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    len_d       = len_q;
    rem_d       = rem_q;
    vc_d        = vc_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    data_d      = '0;
    cmd_ready_o = 1'b0;
    pl_ready_o  = 1'b0;
    cand        = allocatable_i & on_off_i;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so the command side sees not-ready while held in reset.
        cmd_ready_o = rst;
        if (cmd_valid_i && rst) begin
          x_d     = cmd_x_dest_i;
          y_d     = cmd_y_dest_i;
          len_d   = cmd_len_i;
          state_d = ST_ALLOC;
        end
      end

      ST_ALLOC: begin
        if (|cand) begin
          // Descending scan so the lowest candidate VC is the one that sticks.
          for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (cand[i]) vc_d = VC_W'(i);
          end
          state_d = ST_HEAD;
        end
      end

      ST_HEAD: begin
        if (on_off_i[vc_q]) begin
          valid_d           = 1'b1;
          data_d.vc_id      = vc_q;
          data_d.data       = {x_q, y_q, {PAD_W{1'b0}}};
          if (len_q == '0) begin
            data_d.flit_label = noc_injector_pkg::HEADTAIL;
            cnt_d             = cnt_q + 1'b1;
            state_d           = ST_IDLE;
          end else begin
            data_d.flit_label = noc_injector_pkg::HEAD;
            rem_d             = len_q;
            state_d           = ST_BODY;
          end
        end
      end

      ST_BODY: begin
        pl_ready_o = on_off_i[vc_q];
        if (pl_valid_i && on_off_i[vc_q]) begin
          valid_d      = 1'b1;
          data_d.vc_id = vc_q;
          data_d.data  = pl_data_i;
          if (rem_q == LEN_W'(1)) begin
            data_d.flit_label = noc_injector_pkg::TAIL;
            cnt_d             = cnt_q + 1'b1;
            state_d           = ST_IDLE;
          end else begin
            data_d.flit_label = noc_injector_pkg::BODY;
            rem_d             = rem_q - 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_noc_injector.sv
// Directed self-checking bench for noc_injector: flit sequences, flow-control
// stalls, VC allocation waits, counter wrap and mid-packet reset.
module tb_noc_injector;
  import noc_injector_pkg::*;

  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [3:0]        cmd_x_dest_i = '0;
  logic [3:0]        cmd_y_dest_i = '0;
  logic [LEN_W-1:0]  cmd_len_i = '0;
  logic              pl_valid_i = 1'b0;
  logic              pl_ready_o;
  logic [31:0]       pl_data_i = '0;
  flit_t             data_o;
  logic              valid_o;
  logic [1:0]        on_off_i = '0;
  logic [1:0]        allocatable_i = '0;
  logic              busy_o;
  logic [CNT_W-1:0]  sent_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hsCyc = 0;
  flit_t       fq[$];
  int          fc[$];
  logic [31:0] plq[$];

  noc_injector #(.VC_NUM(2), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_dest_i(cmd_x_dest_i), .cmd_y_dest_i(cmd_y_dest_i), .cmd_len_i(cmd_len_i),
    .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
    .data_o(data_o), .valid_o(valid_o),
    .on_off_i(on_off_i), .allocatable_i(allocatable_i),
    .busy_o(busy_o), .sent_cnt_o(sent_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every presented flit with the cycle it became visible.
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      fq.push_back(data_o);
      fc.push_back(cyc);
    end
  end

  // Payload source: presents the queue head, pops on each handshake.
  always @(negedge clk) begin
    pl_valid_i = (plq.size() > 0);
    pl_data_i  = (plq.size() > 0) ? plq[0] : 32'h0;
  end

  always @(posedge clk) begin
    if (rst && pl_valid_i && pl_ready_o) void'(plq.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic flit_t mkFlit(input flit_label_t l, input logic v, input logic [31:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = v;
    f.data       = d;
    return f;
  endfunction

  task automatic checkFlit(input string tag, input int idx, input flit_label_t l, input logic v,
                           input logic [31:0] d, input int expCyc);
    flit_t f;
    int    c;
    f = '1;
    c = -1;
    if (idx < fq.size()) begin
      f = fq[idx];
      c = fc[idx];
    end
    checkOutput(tag, 64'(f), 64'(mkFlit(l, v, d)));
    checkOutput({tag, "_cycle"}, 64'(c), 64'(expCyc));
  endtask

  // Drive one command; hsCyc is the cycle number of the accepting edge.
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic [LEN_W-1:0] len);
    @(negedge clk);
    cmd_valid_i  = 1'b1;
    cmd_x_dest_i = x;
    cmd_y_dest_i = y;
    cmd_len_i    = len;
    #1;
    checkOutput("cmd_ready_at_cmd", 64'(cmd_ready_o), 64'd1);
    @(posedge clk);
    #1;
    hsCyc = cyc;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    // Held in reset, then released with no command pending.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    checkOutput("rst_data", 64'(data_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("idle_valid", 64'(valid_o), 64'd0);
    checkOutput("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("idle_sent_cnt", 64'(sent_cnt_o), 64'd0);
    checkOutput("idle_busy", 64'(busy_o), 64'd0);

    // Single HEADTAIL packet on vc 0.
    allocatable_i = 2'b11;
    on_off_i      = 2'b11;
    fq.delete(); fc.delete();
    applyStimulus(4'd2, 4'd1, 4'd0);
    repeat (4) @(negedge clk);
    checkOutput("t2_count", 64'(fq.size()), 64'd1);
    checkFlit("t2_headtail", 0, HEADTAIL, 1'b0, 32'h2100_0000, hsCyc + 2);
    checkOutput("t2_sent_cnt", 64'(sent_cnt_o), 64'd1);

    // Three body flits, continuous payload, vc 1 only allocatable.
    allocatable_i = 2'b10;
    plq = '{32'hA, 32'hB, 32'hC};
    fq.delete(); fc.delete();
    applyStimulus(4'd3, 4'd3, 4'd3);
    repeat (8) @(negedge clk);
    checkOutput("t3_count", 64'(fq.size()), 64'd4);
    checkFlit("t3_head", 0, HEAD, 1'b1, 32'h3300_0000, hsCyc + 2);
    checkFlit("t3_body0", 1, BODY, 1'b1, 32'hA, hsCyc + 3);
    checkFlit("t3_body1", 2, BODY, 1'b1, 32'hB, hsCyc + 4);
    checkFlit("t3_tail", 3, TAIL, 1'b1, 32'hC, hsCyc + 5);
    checkOutput("t3_sent_cnt", 64'(sent_cnt_o), 64'd2);
    checkOutput("t3_payload_left", 64'(plq.size()), 64'd0);

    // on_off of vc 0 dropped for three cycles right after the head.
    allocatable_i = 2'b11;
    plq = '{32'h11, 32'h22};
    fq.delete(); fc.delete();
    applyStimulus(4'd1, 4'd2, 4'd2);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      on_off_i = 2'b10;
      #1;
      checkOutput("t4_stall_pl_ready", 64'(pl_ready_o), 64'd0);
    end
    @(negedge clk);
    on_off_i = 2'b11;
    repeat (5) @(negedge clk);
    checkOutput("t4_count", 64'(fq.size()), 64'd3);
    checkFlit("t4_head", 0, HEAD, 1'b0, 32'h1200_0000, hsCyc + 2);
    checkFlit("t4_body", 1, BODY, 1'b0, 32'h11, hsCyc + 6);
    checkFlit("t4_tail", 2, TAIL, 1'b0, 32'h22, hsCyc + 7);
    checkOutput("t4_sent_cnt", 64'(sent_cnt_o), 64'd3);

    // Nothing allocatable for five cycles, then vc 1 becomes available.
    allocatable_i = 2'b00;
    fq.delete(); fc.delete();
    applyStimulus(4'd5, 4'd3, 4'd0);
    repeat (5) begin
      @(negedge clk);
      #1;
      checkOutput("t5_alloc_busy", 64'(busy_o), 64'd1);
      checkOutput("t5_alloc_valid", 64'(valid_o), 64'd0);
    end
    allocatable_i = 2'b10;
    repeat (4) @(negedge clk);
    checkOutput("t5_count", 64'(fq.size()), 64'd1);
    checkFlit("t5_headtail", 0, HEADTAIL, 1'b1, 32'h5300_0000, hsCyc + 7);
    checkOutput("t5_sent_cnt", 64'(sent_cnt_o), 64'd4);

    // Fill the 8-bit counter to its maximum, then wrap it.
    allocatable_i = 2'b11;
    for (int p = 0; p < 251; p++) begin
      applyStimulus(4'd0, 4'd0, 4'd0);
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("t6_cnt_max", 64'(sent_cnt_o), 64'hFF);
    applyStimulus(4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("t6_cnt_wrap", 64'(sent_cnt_o), 64'd0);
    applyStimulus(4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("t6_cnt_after_wrap", 64'(sent_cnt_o), 64'd1);

    // Reset lands mid-clock while the first body flit of a len=4 packet is out.
    plq = '{32'h1, 32'h2, 32'h3, 32'h4};
    fq.delete(); fc.delete();
    applyStimulus(4'd7, 4'd6, 4'd4);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_pre_reset_valid", 64'(valid_o), 64'd1);
    checkOutput("t6_pre_reset_flit", 64'(data_o), 64'(mkFlit(BODY, 1'b0, 32'h1)));
    rst = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(valid_o), 64'd0);
    checkOutput("t6_async_data", 64'(data_o), 64'd0);
    checkOutput("t6_async_busy", 64'(busy_o), 64'd0);
    checkOutput("t6_async_cmd_ready", 64'(cmd_ready_o), 64'd0);
    checkOutput("t6_async_pl_ready", 64'(pl_ready_o), 64'd0);
    checkOutput("t6_async_sent_cnt", 64'(sent_cnt_o), 64'd0);
    plq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t6_no_tail_count", 64'(fq.size()), 64'd2);
    checkOutput("t6_post_busy", 64'(busy_o), 64'd0);
    checkOutput("t6_post_cmd_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("t6_post_sent_cnt", 64'(sent_cnt_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
